// File: rtl/e203_exu_alu_dpath_arb.sv
// ---------------------------------------------------------------------------
// e203_exu_alu_dpath_arb
//
// Shares one ALU adder/comparator datapath among N_REQ requesters
// (0=ALU, 1=BJP, 2=AGU, 3=MDV). One requester is granted per cycle. Its
// operands are steered to the datapath, and the datapath result is
// registered into a single-entry tagged response buffer.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-requester request valid               [N_REQ]
//   req_ready       per-requester grant (one-hot or zero)     [N_REQ]
//   req_lock        keep ownership for the following op       [N_REQ]
//   req_op1/op2     flattened operands, requester i at [i*DW +: DW]
//   req_op          flattened one-hot ops, requester i at [i*OPW +: OPW]
//   dp_op1/op2/op   steered operands/op to the shared datapath (0 if idle)
//   dp_add_res      datapath adder result (combinational from dp_*)
//   dp_cmp_res      datapath compare result (combinational from dp_*)
//   rsp_valid       registered result valid
//   rsp_ready       result accepted by the tagged requester
//   rsp_id          index of the requester owning the result
//   rsp_add_res     registered adder result
//   rsp_cmp_res     registered compare result
//
// Build option
//   E203_ALU_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins,
//                               no round-robin pointer. Undefined (default):
//                               round-robin starting at ptr.
//   Lock behaviour is identical in both builds.
// ---------------------------------------------------------------------------
module e203_exu_alu_dpath_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int OPW   = 9,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_lock,
    input  logic [N_REQ*DW-1:0]  req_op1,
    input  logic [N_REQ*DW-1:0]  req_op2,
    input  logic [N_REQ*OPW-1:0] req_op,
    output logic [DW-1:0]        dp_op1,
    output logic [DW-1:0]        dp_op2,
    output logic [OPW-1:0]       dp_op,
    input  logic [DW-1:0]        dp_add_res,
    input  logic                 dp_cmp_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_add_res,
    output logic                 rsp_cmp_res
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_reg,   state_next;
    logic [IDW-1:0]   lock_own_reg, lock_own_next;
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   ptr_reg,     ptr_next;
`endif
    logic             rsp_valid_reg,   rsp_valid_next;
    logic [IDW-1:0]   rsp_id_reg,      rsp_id_next;
    logic [DW-1:0]    rsp_add_res_reg, rsp_add_res_next;
    logic             rsp_cmp_res_reg, rsp_cmp_res_next;

    logic             can_issue;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;

    // Per-requester views of the flattened operand buses.
    logic [DW-1:0]    op1_arr [N_REQ];
    logic [DW-1:0]    op2_arr [N_REQ];
    logic [OPW-1:0]   op_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op1_arr[gi]   = req_op1[gi*DW +: DW];
            assign op2_arr[gi]   = req_op2[gi*DW +: DW];
            assign op_arr[gi]    = req_op[gi*OPW +: OPW];
            assign req_ready[gi] = grant_any && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Single-entry output buffer: a new op may issue when the buffer is
    // empty or is being drained this very cycle.
    assign can_issue = !rsp_valid_reg || rsp_ready;

    // Winner selection. Gated by rst so nothing is granted while in reset.
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
    logic [IDW:0] cand;
`endif
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
        cand      = '0;
`endif
        if (!rst && can_issue) begin
            if (state_reg == LOCKED) begin
                // Only the lock owner may issue; if it is not valid, the
                // datapath simply idles while the lock is kept.
                if (req_valid[lock_own_reg]) begin
                    grant_any = 1'b1;
                    grant_idx = lock_own_reg;
                end
            end else begin
`ifdef E203_ALU_ARB_FIXED_PRIO_EN
                // Scan high to low so the lowest valid index wins last.
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    if (req_valid[k]) begin
                        grant_any = 1'b1;
                        grant_idx = IDW'(k);
                    end
                end
`else
                // Scan ptr, ptr+1, ... with wrap; first valid one wins.
                for (int k = 0; k < N_REQ; k++) begin
                    cand = {1'b0, ptr_reg} + (IDW+1)'(k);
                    if (cand >= (IDW+1)'(N_REQ)) begin
                        cand = cand - (IDW+1)'(N_REQ);
                    end
                    if (!grant_any && req_valid[cand[IDW-1:0]]) begin
                        grant_any = 1'b1;
                        grant_idx = cand[IDW-1:0];
                    end
                end
`endif
            end
        end
    end

    // Datapath steering; zeros when nobody is granted.
    always_comb begin
        dp_op1 = '0;
        dp_op2 = '0;
        dp_op  = '0;
        if (grant_any) begin
            dp_op1 = op1_arr[grant_idx];
            dp_op2 = op2_arr[grant_idx];
            dp_op  = op_arr[grant_idx];
        end
    end

    // Next-state and response buffer update.
    always_comb begin
        state_next       = state_reg;
        lock_own_next    = lock_own_reg;
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
        ptr_next         = ptr_reg;
`endif
        rsp_valid_next   = rsp_valid_reg && !rsp_ready;
        rsp_id_next      = rsp_id_reg;
        rsp_add_res_next = rsp_add_res_reg;
        rsp_cmp_res_next = rsp_cmp_res_reg;

        if (grant_any) begin
            rsp_valid_next   = 1'b1;
            rsp_id_next      = grant_idx;
            rsp_add_res_next = dp_add_res;
            rsp_cmp_res_next = dp_cmp_res;
            if (req_lock[grant_idx]) begin
                // Pointer stays put while a lock sequence runs.
                state_next    = LOCKED;
                lock_own_next = grant_idx;
            end else begin
                state_next    = IDLE;
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
                ptr_next      = (grant_idx == IDW'(N_REQ - 1)) ? '0
                                                              : grant_idx + IDW'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lock_own_reg    <= '0;
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
            ptr_reg         <= '0;
`endif
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_add_res_reg <= '0;
            rsp_cmp_res_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lock_own_reg    <= lock_own_next;
`ifndef E203_ALU_ARB_FIXED_PRIO_EN
            ptr_reg         <= ptr_next;
`endif
            rsp_valid_reg   <= rsp_valid_next;
            rsp_id_reg      <= rsp_id_next;
            rsp_add_res_reg <= rsp_add_res_next;
            rsp_cmp_res_reg <= rsp_cmp_res_next;
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_add_res = rsp_add_res_reg;
    assign rsp_cmp_res = rsp_cmp_res_reg;

endmodule

// File: tb/tb_e203_exu_alu_dpath_arb.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_alu_dpath_arb
//
// Self-checking bench for e203_exu_alu_dpath_arb (default parameters).
// The bench models the shared datapath. For every expected grant it pushes
// the expected tagged result into a scoreboard queue, then pops and compares
// it when the DUT presents it. Expected grants follow round-robin order, or
// fixed priority when E203_ALU_ARB_FIXED_PRIO_EN is defined.
// ---------------------------------------------------------------------------
module tb_e203_exu_alu_dpath_arb;

    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int OPW   = 9;
    localparam int IDW   = 2;

    // one-hot op bit positions
    localparam int OP_EQ = 0, OP_NE = 1, OP_LT = 2, OP_GT = 3, OP_LTU = 4;
    localparam int OP_GTU = 5, OP_ADD = 6, OP_SUB = 7, OP_XOR = 8;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  add;
        logic           cmp;
    } rsp_t;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     req_lock;
    logic [N_REQ*DW-1:0]  req_op1;
    logic [N_REQ*DW-1:0]  req_op2;
    logic [N_REQ*OPW-1:0] req_op;
    logic [DW-1:0]        dp_op1;
    logic [DW-1:0]        dp_op2;
    logic [OPW-1:0]       dp_op;
    logic [DW-1:0]        dp_add_res;
    logic                 dp_cmp_res;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_add_res;
    logic                 rsp_cmp_res;

    logic [DW-1:0]  op1 [N_REQ];
    logic [DW-1:0]  op2 [N_REQ];
    logic [OPW-1:0] opv [N_REQ];

    rsp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    e203_exu_alu_dpath_arb #(
        .N_REQ(N_REQ), .DW(DW), .OPW(OPW), .IDW(IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_lock   (req_lock),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_op     (req_op),
        .dp_op1     (dp_op1),
        .dp_op2     (dp_op2),
        .dp_op      (dp_op),
        .dp_add_res (dp_add_res),
        .dp_cmp_res (dp_cmp_res),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_add_res(rsp_add_res),
        .rsp_cmp_res(rsp_cmp_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference adder/comparator, used both as the datapath and for expectations.
    function automatic rsp_t calc(input logic [IDW-1:0] id, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [OPW-1:0] op);
        rsp_t r;
        r.id  = id;
        r.add = op[OP_SUB] ? a - b : (op[OP_XOR] ? a ^ b : a + b);
        r.cmp = (op[OP_EQ]  && (a == b)) ||
                (op[OP_NE]  && (a != b)) ||
                (op[OP_LT]  && ($signed(a) < $signed(b))) ||
                (op[OP_GT]  && ($signed(a) > $signed(b))) ||
                (op[OP_LTU] && (a < b)) ||
                (op[OP_GTU] && (a > b));
        return r;
    endfunction

    rsp_t dp_model;
    always_comb begin
        dp_model   = calc('0, dp_op1, dp_op2, dp_op);
        dp_add_res = dp_model.add;
        dp_cmp_res = dp_model.cmp;
    end

    always_comb begin
        req_op1 = '0;
        req_op2 = '0;
        req_op  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_op1[i*DW +: DW]   = op1[i];
            req_op2[i*DW +: DW]   = op2[i];
            req_op[i*OPW +: OPW]  = opv[i];
        end
    end

    function automatic logic [OPW-1:0] onehot(input int b);
        logic [OPW-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rsp_t e;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_lock  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            op1[i] = 32'(100 + i);
            op2[i] = 32'(3);
            opv[i] = onehot(OP_ADD);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ready c=%0d got %b expected 0000", c, req_ready);
            end
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_add_res, rsp_cmp_res} !== '0) begin
                n_bad++;
                $display("FAIL reset_rsp c=%0d got v=%b id=%0d add=%h cmp=%b expected all zero",
                         c, rsp_valid, rsp_id, rsp_add_res, rsp_cmp_res);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_first_grant got %b expected 0001", req_ready);
        end
        q.push_back(calc(2'd0, op1[0], op2[0], opv[0]));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        e = q.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_add_res, rsp_cmp_res} !== e) begin
            n_bad++;
            $display("FAIL reset_first_rsp got v=%b id=%0d add=%h expected v=1 id=%0d add=%h",
                     rsp_valid, rsp_id, rsp_add_res, e.id, e.add);
        end
        $display("reset: first grant id=0 checked");
    endtask

    task automatic test_round_robin();
        logic [3:0] tv[$] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
`ifdef E203_ALU_ARB_FIXED_PRIO_EN
        int         tg[$] = '{0, 0, 0, 0, 0, -1, -1};
`else
        int         tg[$] = '{0, 1, 2, 3, 0, -1, -1};
`endif
        logic [3:0] er;
        do_reset();
        op1[0] = 32'h0000_0010; op2[0] = 32'h0000_0007; opv[0] = onehot(OP_ADD);
        op1[1] = 32'h0000_0003; op2[1] = 32'h0000_0009; opv[1] = onehot(OP_LTU);
        op1[2] = 32'h0000_0020; op2[2] = 32'h0000_0005; opv[2] = onehot(OP_SUB);
        op1[3] = 32'hF0F0_F0F0; op2[3] = 32'h0FF0_0FF0; opv[3] = onehot(OP_XOR);
        for (int c = 0; c < tv.size(); c++) begin
            req_valid = tv[c];
            req_lock  = '0;
            rsp_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL rr_rsp_valid c=%0d got %b expected %b", c, rsp_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_cmp++;
                if ({rsp_id, rsp_add_res, rsp_cmp_res} !== q[0]) begin
                    n_bad++;
                    $display("FAIL rr_rsp c=%0d got id=%0d add=%h cmp=%b expected id=%0d add=%h cmp=%b",
                             c, rsp_id, rsp_add_res, rsp_cmp_res, q[0].id, q[0].add, q[0].cmp);
                end
                void'(q.pop_front());
            end
            er = (tg[c] >= 0) ? 4'(1 << tg[c]) : 4'b0000;
            n_cmp++;
            if (req_ready !== er) begin
                n_bad++;
                $display("FAIL rr_grant c=%0d got %b expected %b", c, req_ready, er);
            end
            if (tg[c] >= 0) q.push_back(calc(IDW'(tg[c]), op1[tg[c]], op2[tg[c]], opv[tg[c]]));
            $display("round_robin c=%0d ready=%b rsp_valid=%b id=%0d", c, req_ready, rsp_valid, rsp_id);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] tv[$] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic       tr[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         tg[$] = '{1, -1, -1, -1, -1, 0, -1, -1};
        logic [3:0] er;
        do_reset();
        op1[0] = 32'h0000_000A; op2[0] = 32'h0000_0014; opv[0] = onehot(OP_ADD);
        op1[1] = 32'h0000_0005; op2[1] = 32'h0000_0005; opv[1] = onehot(OP_EQ);
        for (int c = 0; c < tv.size(); c++) begin
            req_valid = tv[c];
            req_lock  = '0;
            rsp_ready = tr[c];
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL bp_rsp_valid c=%0d got %b expected %b", c, rsp_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_cmp++;
                if ({rsp_id, rsp_add_res, rsp_cmp_res} !== q[0]) begin
                    n_bad++;
                    $display("FAIL bp_rsp c=%0d got id=%0d add=%h cmp=%b expected id=%0d add=%h cmp=%b",
                             c, rsp_id, rsp_add_res, rsp_cmp_res, q[0].id, q[0].add, q[0].cmp);
                end
                if (tr[c]) void'(q.pop_front());
            end
            er = (tg[c] >= 0) ? 4'(1 << tg[c]) : 4'b0000;
            n_cmp++;
            if (req_ready !== er) begin
                n_bad++;
                $display("FAIL bp_grant c=%0d got %b expected %b", c, req_ready, er);
            end
            if (tg[c] >= 0) q.push_back(calc(IDW'(tg[c]), op1[tg[c]], op2[tg[c]], opv[tg[c]]));
            $display("back_pressure c=%0d rsp_ready=%b ready=%b rsp_valid=%b id=%0d cmp=%b",
                     c, tr[c], req_ready, rsp_valid, rsp_id, rsp_cmp_res);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add_path();
        logic [3:0] tv[$] = '{4'b0100, 4'b0001, 4'b0000, 4'b0000};
        int         tg[$] = '{2, 0, -1, -1};
        logic [3:0] er;
        do_reset();
        op1[2] = 32'hFFFF_FFFF; op2[2] = 32'h0000_0001; opv[2] = onehot(OP_ADD);
        op1[0] = 32'h0000_0003; op2[0] = 32'h0000_0005; opv[0] = onehot(OP_SUB) | onehot(OP_LT);
        for (int c = 0; c < tv.size(); c++) begin
            req_valid = tv[c];
            req_lock  = '0;
            rsp_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL add_rsp_valid c=%0d got %b expected %b", c, rsp_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_cmp++;
                if ({rsp_id, rsp_add_res, rsp_cmp_res} !== q[0]) begin
                    n_bad++;
                    $display("FAIL add_rsp c=%0d got id=%0d add=%h cmp=%b expected id=%0d add=%h cmp=%b",
                             c, rsp_id, rsp_add_res, rsp_cmp_res, q[0].id, q[0].add, q[0].cmp);
                end
                void'(q.pop_front());
            end
            er = (tg[c] >= 0) ? 4'(1 << tg[c]) : 4'b0000;
            n_cmp++;
            if (req_ready !== er) begin
                n_bad++;
                $display("FAIL add_grant c=%0d got %b expected %b", c, req_ready, er);
            end
            if (tg[c] >= 0) begin
                n_cmp++;
                if ({dp_op1, dp_op2, dp_op} !== {op1[tg[c]], op2[tg[c]], opv[tg[c]]}) begin
                    n_bad++;
                    $display("FAIL add_steer c=%0d got %h/%h/%h expected %h/%h/%h", c, dp_op1, dp_op2,
                             dp_op, op1[tg[c]], op2[tg[c]], opv[tg[c]]);
                end
                q.push_back(calc(IDW'(tg[c]), op1[tg[c]], op2[tg[c]], opv[tg[c]]));
            end
            $display("add_path c=%0d ready=%b rsp_valid=%b id=%0d add=%h", c, req_ready, rsp_valid,
                     rsp_id, rsp_add_res);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lock();
        // MDV takes the lock, holds it over 3 locked ops plus a final unlocked
        // op, then ALU/BJP resume. Second half: lock owner stalls 2 cycles.
        logic [3:0] tv[$] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0011, 4'b0011,
                              4'b1000, 4'b0010, 4'b0010, 4'b1010, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] tl[$] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                              4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`ifdef E203_ALU_ARB_FIXED_PRIO_EN
        int         tg[$] = '{3, 3, 3, 3, 0, 0, 3, -1, -1, 3, 1, -1, -1};
`else
        int         tg[$] = '{3, 3, 3, 3, 0, 1, 3, -1, -1, 3, 1, -1, -1};
`endif
        logic [3:0] er;
        do_reset();
        op1[0] = 32'h0000_1000; op2[0] = 32'h0000_0001; opv[0] = onehot(OP_ADD);
        op1[1] = 32'h8000_0000; op2[1] = 32'h0000_0001; opv[1] = onehot(OP_LT);
        op1[3] = 32'h0000_0007; op2[3] = 32'h0000_0002; opv[3] = onehot(OP_SUB) | onehot(OP_GTU);
        for (int c = 0; c < tv.size(); c++) begin
            req_valid = tv[c];
            req_lock  = tl[c];
            rsp_ready = 1'b1;
            op1[3]    = 32'(7 + c);
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL lock_rsp_valid c=%0d got %b expected %b", c, rsp_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_cmp++;
                if ({rsp_id, rsp_add_res, rsp_cmp_res} !== q[0]) begin
                    n_bad++;
                    $display("FAIL lock_rsp c=%0d got id=%0d add=%h cmp=%b expected id=%0d add=%h cmp=%b",
                             c, rsp_id, rsp_add_res, rsp_cmp_res, q[0].id, q[0].add, q[0].cmp);
                end
                void'(q.pop_front());
            end
            er = (tg[c] >= 0) ? 4'(1 << tg[c]) : 4'b0000;
            n_cmp++;
            if (req_ready !== er) begin
                n_bad++;
                $display("FAIL lock_grant c=%0d got %b expected %b", c, req_ready, er);
            end
            if (tg[c] >= 0) begin
                q.push_back(calc(IDW'(tg[c]), op1[tg[c]], op2[tg[c]], opv[tg[c]]));
            end else begin
                n_cmp++;
                if ({dp_op1, dp_op2, dp_op} !== '0) begin
                    n_bad++;
                    $display("FAIL lock_idle_dp c=%0d got %h/%h/%h expected zero", c, dp_op1, dp_op2, dp_op);
                end
            end
            $display("lock c=%0d valid=%b lock=%b ready=%b dp_op=%h rsp_id=%0d", c, tv[c], tl[c],
                     req_ready, dp_op, rsp_id);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            op1[i] = '0;
            op2[i] = '0;
            opv[i] = '0;
        end
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_add_path();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
